// File: rtl/nios_adc_sample_writer.sv
// Avalon-MM write master: buffers ADC samples in a small FIFO and writes them,
// zero-extended to 32 bits, to consecutive word addresses from a programmed base.
module nios_adc_sample_writer #(
    parameter int SAMPLE_W   = 12,
    parameter int ADDR_W     = 19,
    parameter int COUNT_W    = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [COUNT_W-1:0]  word_count,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [COUNT_W-1:0]  words_written,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [3:0]          avm_byteenable,
    output logic                avm_write,
    output logic [31:0]         avm_writedata,
    input  logic                avm_waitrequest
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;

    localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1);
    localparam logic [OCC_W-1:0]   OCC_ONE    = OCC_W'(1);
    localparam logic [OCC_W-1:0]   OCC_FULL   = OCC_W'(FIFO_DEPTH);
    localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);
    localparam logic [ADDR_W-1:0]  ADDR_FOUR  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0]  ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [SAMPLE_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [OCC_W-1:0]    occ_reg;

    logic [COUNT_W-1:0]  count_reg;
    logic [COUNT_W-1:0]  issued_reg;
    logic [COUNT_W-1:0]  words_written_reg;
    logic [ADDR_W-1:0]   addr_ptr_reg;
    logic [ADDR_W-1:0]   avm_address_reg;
    logic [31:0]         avm_writedata_reg;
    logic                avm_write_reg;
    logic                overflow_reg;
    logic                done_reg;

    logic                accepted, last_accept, fifo_full, fifo_empty, room_in_count;
    logic [COUNT_W:0]    committed;
    logic [COUNT_W-1:0]  ww_inc;
    logic [SAMPLE_W-1:0] head_sample;
    logic [31:0]         head_word;

    logic push, pop, drop_set, start_go, start_zero, finish, flush;

    assign accepted    = avm_write_reg & ~avm_waitrequest;
    assign ww_inc      = words_written_reg + COUNT_ONE;
    assign last_accept = accepted && (ww_inc == count_reg);
    assign fifo_full   = (occ_reg == OCC_FULL);
    assign fifo_empty  = (occ_reg == '0);
    // Words already issued plus those buffered must stay below the capture length.
    assign committed     = {1'b0, issued_reg} + {{(COUNT_W+1-OCC_W){1'b0}}, occ_reg};
    assign room_in_count = committed < {1'b0, count_reg};

    assign head_sample = fifo_mem[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_zext
            if (gi < SAMPLE_W) begin : g_bit
                assign head_word[gi] = head_sample[gi];
            end else begin : g_zero
                assign head_word[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start && (word_count != '0)) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (last_accept) begin
                    state_next = S_IDLE;
                end else if (abort) begin
                    state_next = (avm_write_reg && !accepted) ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (accepted) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_reg != S_IDLE);
        start_go   = (state_reg == S_IDLE) && start;
        start_zero = start_go && (word_count == '0);
        finish     = (state_reg != S_IDLE) && (state_next == S_IDLE);
        flush      = start_go || finish;
        push       = (state_reg == S_RUN) && sample_valid && room_in_count && !fifo_full;
        drop_set   = (state_reg == S_RUN) && sample_valid && room_in_count && fifo_full;
        pop        = (state_reg == S_RUN) && !abort && (!avm_write_reg || accepted)
                     && !fifo_empty && (issued_reg < count_reg);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= sample_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            occ_reg           <= '0;
            count_reg         <= '0;
            issued_reg        <= '0;
            words_written_reg <= '0;
            addr_ptr_reg      <= '0;
            avm_address_reg   <= '0;
            avm_writedata_reg <= '0;
            avm_write_reg     <= 1'b0;
            overflow_reg      <= 1'b0;
            done_reg          <= 1'b0;
        end else begin
            done_reg <= finish || start_zero;

            if (start_go) begin
                count_reg         <= word_count;
                issued_reg        <= '0;
                words_written_reg <= '0;
                overflow_reg      <= 1'b0;
                addr_ptr_reg      <= base_addr & ALIGN_MASK;
            end else begin
                if (drop_set) begin
                    overflow_reg <= 1'b1;
                end
                if (accepted) begin
                    words_written_reg <= ww_inc;
                end
                if (pop) begin
                    issued_reg   <= issued_reg + COUNT_ONE;
                    addr_ptr_reg <= addr_ptr_reg + ADDR_FOUR;
                end
            end

            // The write register only changes when idle or on acceptance, so it holds under stall.
            if (pop) begin
                avm_write_reg     <= 1'b1;
                avm_address_reg   <= addr_ptr_reg;
                avm_writedata_reg <= head_word;
            end else if (accepted) begin
                avm_write_reg <= 1'b0;
            end

            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                occ_reg    <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                end
                case ({push, pop})
                    2'b10:   occ_reg <= occ_reg + OCC_ONE;
                    2'b01:   occ_reg <= occ_reg - OCC_ONE;
                    default: occ_reg <= occ_reg;
                endcase
            end
        end
    end

    assign done           = done_reg;
    assign overflow       = overflow_reg;
    assign words_written  = words_written_reg;
    assign avm_address    = avm_address_reg;
    assign avm_byteenable = 4'hF;
    assign avm_write      = avm_write_reg;
    assign avm_writedata  = avm_writedata_reg;

endmodule

// File: tb/tb_nios_adc_sample_writer.sv
// Scoreboard bench for nios_adc_sample_writer: expected writes are queued as samples
// are driven and checked as the master's writes are accepted.
module tb_nios_adc_sample_writer;

    localparam int SAMPLE_W   = 12;
    localparam int ADDR_W     = 19;
    localparam int COUNT_W    = 17;
    localparam int FIFO_DEPTH = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [ADDR_W-1:0]   base_addr = '0;
    logic [COUNT_W-1:0]  word_count = '0;
    logic                sample_valid = 1'b0;
    logic [SAMPLE_W-1:0] sample_data = '0;
    logic                busy, done, overflow;
    logic [COUNT_W-1:0]  words_written;
    logic [ADDR_W-1:0]   avm_address;
    logic [3:0]          avm_byteenable;
    logic                avm_write;
    logic [31:0]         avm_writedata;
    logic                avm_waitrequest = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int writes_seen = 0;
    int done_seen   = 0;

    logic [ADDR_W-1:0] exp_addr_q [$];
    logic [31:0]       exp_data_q [$];

    logic              held_valid = 1'b0;
    logic [ADDR_W-1:0] held_addr;
    logic [31:0]       held_data;

    nios_adc_sample_writer #(
        .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W), .COUNT_W(COUNT_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .busy(busy), .done(done), .overflow(overflow), .words_written(words_written),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
        $fatal(1, "timeout");
    end

    // Slave-side monitor, sampled mid-cycle when inputs and outputs are settled.
    always @(negedge clk) begin
        logic [ADDR_W-1:0] ea;
        logic [31:0]       ed;
        #2;
        if (done) done_seen++;
        if (reset) begin
            held_valid = 1'b0;
        end else if (avm_write) begin
            if (held_valid) begin
                n_checks++;
                if (avm_address !== held_addr || avm_writedata !== held_data) begin
                    n_fail++;
                    $display("FAIL hold_stable: addr=%h data=%h, required addr=%h data=%h",
                             avm_address, avm_writedata, held_addr, held_data);
                end
            end
            if (!avm_waitrequest) begin
                writes_seen++;
                n_checks++;
                if (exp_addr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: addr=%h data=%h, required no write",
                             avm_address, avm_writedata);
                end else begin
                    ea = exp_addr_q.pop_front();
                    ed = exp_data_q.pop_front();
                    if (avm_address !== ea || avm_writedata !== ed || avm_byteenable !== 4'hF) begin
                        n_fail++;
                        $display("FAIL write_content: addr=%h data=%h be=%h, required addr=%h data=%h be=f",
                                 avm_address, avm_writedata, avm_byteenable, ea, ed);
                    end else begin
                        $display("write addr=%h data=%h", avm_address, avm_writedata);
                    end
                end
                held_valid = 1'b0;
            end else begin
                held_valid = 1'b1;
                held_addr  = avm_address;
                held_data  = avm_writedata;
            end
        end else if (held_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL hold_write: avm_write=0 during stall, required 1");
            held_valid = 1'b0;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [SAMPLE_W-1:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back({{(32-SAMPLE_W){1'b0}}, d});
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [COUNT_W-1:0] wc);
        @(negedge clk);
        base_addr = b; word_count = wc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_sample(input logic [SAMPLE_W-1:0] d);
        @(negedge clk);
        sample_valid = 1'b1; sample_data = d;
    endtask

    task automatic end_samples();
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int i = 0; i < budget && busy; i++) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycles(3);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || words_written !== '0 ||
            avm_write !== 1'b0 || avm_address !== '0 || avm_writedata !== '0 || avm_byteenable !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b ovf=%b ww=%0d wr=%b addr=%h data=%h be=%h, required zeros be=f",
                     busy, done, overflow, words_written, avm_write, avm_address, avm_writedata, avm_byteenable);
        end
        reset = 1'b0;
        cycles(1);
    endtask

    task automatic test_basic();
        int d0 = done_seen;
        int w0 = writes_seen;
        do_start(19'h100, 3);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: busy=%b, required 1", busy);
        end
        for (int i = 0; i < 3; i++) expect_write(19'h100 + 19'(4 * i), 12'(i + 1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1) begin
                n_checks++;
                if (avm_write !== 1'b0) begin
                    n_fail++;
                    $display("FAIL latency_early: avm_write=%b, required 0", avm_write);
                end
            end
            if (i == 2) begin
                n_checks++;
                if (avm_write !== 1'b1) begin
                    n_fail++;
                    $display("FAIL latency_on_time: avm_write=%b, required 1", avm_write);
                end
            end
            sample_valid = 1'b1; sample_data = 12'(i + 1);
        end
        end_samples();
        wait_idle(50, "basic");
        cycles(2);
        n_checks++;
        if (done_seen - d0 != 1 || words_written !== 17'd3 || overflow !== 1'b0 ||
            writes_seen - w0 != 3 || exp_addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_result: done=%0d ww=%0d ovf=%b writes=%0d left=%0d, required 1 3 0 3 0",
                     done_seen - d0, words_written, overflow, writes_seen - w0, exp_addr_q.size());
        end
    endtask

    task automatic test_stall();
        int w0 = writes_seen;
        avm_waitrequest = 1'b1;
        do_start(19'h200, 3);
        for (int i = 0; i < 3; i++) expect_write(19'h200 + 19'(4 * i), 12'h0A0 + 12'(i));
        for (int i = 0; i < 3; i++) send_sample(12'h0A0 + 12'(i));
        end_samples();
        cycles(2);
        n_checks++;
        if (avm_write !== 1'b1 || writes_seen != w0) begin
            n_fail++;
            $display("FAIL stall_pending: wr=%b writes=%0d, required 1 0", avm_write, writes_seen - w0);
        end
        avm_waitrequest = 1'b0;
        wait_idle(50, "stall");
        cycles(1);
        n_checks++;
        if (words_written !== 17'd3 || overflow !== 1'b0 || writes_seen - w0 != 3) begin
            n_fail++;
            $display("FAIL stall_result: ww=%0d ovf=%b writes=%0d, required 3 0 3",
                     words_written, overflow, writes_seen - w0);
        end
    endtask

    task automatic test_overflow();
        int w0 = writes_seen;
        int d0 = done_seen;
        avm_waitrequest = 1'b1;
        do_start(19'h300, 8);
        for (int i = 0; i < 5; i++) expect_write(19'h300 + 19'(4 * i), 12'h100 + 12'(i));
        for (int i = 0; i < 6; i++) send_sample(12'h100 + 12'(i));
        end_samples();
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_flag: overflow=%b, required 1", overflow);
        end
        cycles(14);
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 50 && (writes_seen - w0) < 5; i++) @(negedge clk);
        cycles(3);
        n_checks++;
        if (writes_seen - w0 != 5 || words_written !== 17'd5 || busy !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_result: writes=%0d ww=%0d busy=%b ovf=%b, required 5 5 1 1",
                     writes_seen - w0, words_written, busy, overflow);
        end
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        wait_idle(10, "overflow_abort");
        cycles(1);
        n_checks++;
        if (done_seen - d0 != 1) begin
            n_fail++;
            $display("FAIL overflow_abort_done: pulses=%0d, required 1", done_seen - d0);
        end
    endtask

    task automatic test_zero_count();
        int w0 = writes_seen;
        do_start(19'h600, 0);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0 || words_written !== '0) begin
            n_fail++;
            $display("FAIL zero_count_start: done=%b busy=%b ovf=%b ww=%0d, required 1 0 0 0",
                     done, busy, overflow, words_written);
        end
        cycles(1);
        n_checks++;
        if (done !== 1'b0 || writes_seen != w0) begin
            n_fail++;
            $display("FAIL zero_count_pulse: done=%b writes=%0d, required 0 0", done, writes_seen - w0);
        end
    endtask

    task automatic test_wrap();
        int w0 = writes_seen;
        do_start(19'h7FFFE, 2);
        expect_write(19'h7FFFC, 12'hABC);
        expect_write(19'h00000, 12'hFFF);
        send_sample(12'hABC);
        send_sample(12'hFFF);
        end_samples();
        wait_idle(30, "wrap");
        cycles(1);
        n_checks++;
        if (writes_seen - w0 != 2 || words_written !== 17'd2) begin
            n_fail++;
            $display("FAIL wrap_result: writes=%0d ww=%0d, required 2 2", writes_seen - w0, words_written);
        end
    endtask

    task automatic test_abort();
        int w0 = writes_seen;
        int d0 = done_seen;
        int i;
        avm_waitrequest = 1'b0;
        do_start(19'h800, 10);
        for (int k = 0; k < 5; k++) expect_write(19'h800 + 19'(4 * k), 12'h200 + 12'(k));
        for (int k = 0; k < 5; k++) send_sample(12'h200 + 12'(k));
        @(negedge clk);
        sample_valid = 1'b0;
        for (i = 0; i < 30 && !((writes_seen - w0) == 4 && avm_write); i++) @(negedge clk);
        avm_waitrequest = 1'b1; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || avm_write !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_drain: busy=%b wr=%b done=%b, required 1 1 0", busy, avm_write, done);
        end
        cycles(2);
        avm_waitrequest = 1'b0;
        wait_idle(10, "abort");
        cycles(1);
        n_checks++;
        if (words_written !== 17'd5 || busy !== 1'b0 || done_seen - d0 != 1 || writes_seen - w0 != 5) begin
            n_fail++;
            $display("FAIL abort_result: ww=%0d busy=%b done=%0d writes=%0d, required 5 0 1 5",
                     words_written, busy, done_seen - d0, writes_seen - w0);
        end
        for (int k = 0; k < 3; k++) send_sample(12'h300 + 12'(k));
        end_samples();
        cycles(5);
        n_checks++;
        if (writes_seen - w0 != 5 || overflow !== 1'b0 || words_written !== 17'd5) begin
            n_fail++;
            $display("FAIL idle_ignore: writes=%0d ovf=%b ww=%0d, required 5 0 5",
                     writes_seen - w0, overflow, words_written);
        end
    endtask

    task automatic test_reset_mid_stall();
        int w0 = writes_seen;
        avm_waitrequest = 1'b1;
        do_start(19'h400, 4);
        send_sample(12'h011);
        send_sample(12'h022);
        end_samples();
        for (int i = 0; i < 10 && !avm_write; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (avm_write !== 1'b0 || busy !== 1'b0 || words_written !== '0 || avm_address !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_stall: wr=%b busy=%b ww=%0d addr=%h, required 0 0 0 0",
                     avm_write, busy, words_written, avm_address);
        end
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        do_start(19'h500, 1);
        expect_write(19'h500, 12'h077);
        send_sample(12'h077);
        end_samples();
        wait_idle(20, "post_reset");
        cycles(2);
        n_checks++;
        if (writes_seen - w0 != 1 || words_written !== 17'd1 || exp_addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL post_reset_run: writes=%0d ww=%0d left=%0d, required 1 1 0",
                     writes_seen - w0, words_written, exp_addr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_zero_count();
        test_wrap();
        test_abort();
        test_reset_mid_stall();
        n_checks++;
        if (exp_addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d writes outstanding, required 0", exp_addr_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
